sec60_upcounter: RTL and testbench

Run/stop controlled BCD up-counter, 00 to 59, advanced by an external one-cycle TICK enable. It is the count-up counterpart of the existing down-counting run/stop counter in the exercise designs. A single push switch toggles start/stop, and a second switch clears a paused count. The BCD digits, a wrap carry and the run status drive the board LEDs and 7-segment decoder.

---
 rtl/sec60_upcounter_if.sv | 27 ++
 rtl/sec60_upcounter.sv | 99 +++++++++
 tb/tb_sec60_upcounter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sec60_upcounter_if.sv
// ============================================================================
// sec60_upcounter_if : switch/tick inputs and BCD/status outputs | rev 1.0
// ============================================================================
`default_nettype none

interface sec60_upcounter_if;
  logic       i_sw1;
  logic       i_sw2;
  logic       i_tick;
  logic [3:0] o_lo;
  logic [2:0] o_hi;
  logic       o_carry;
  logic       o_run;
  logic [1:0] o_state;

  modport master (
    output i_sw1, i_sw2, i_tick,
    input  o_lo, o_hi, o_carry, o_run, o_state
  );

  modport slave (
    input  i_sw1, i_sw2, i_tick,
    output o_lo, o_hi, o_carry, o_run, o_state
  );
endinterface

`default_nettype wire

// File: rtl/sec60_upcounter.sv
// ============================================================================
// sec60_upcounter : run/stop BCD up-counter 00..(MOD_HI-1)9 on TICK | rev 1.0
// ============================================================================
`default_nettype none

module sec60_upcounter #(
  parameter int MOD_HI = 6
) (
  input  wire logic         clk,
  input  wire logic         rst,
  sec60_upcounter_if.slave  bus
);

  localparam logic [2:0] c_hi_last = 3'(MOD_HI - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STOP = 2'b10
  } state_t;

  state_t     r_state, w_state_nxt;
  logic       r_sw1_d;
  logic [3:0] r_lo, w_lo_nxt;
  logic [2:0] r_hi, w_hi_nxt;
  logic       r_carry, w_carry_nxt;
  logic       w_press;
  logic       w_count;

  assign w_press = bus.i_sw1 & ~r_sw1_d;
  assign w_count = (r_state == S_RUN) & bus.i_tick;

  always_comb begin
    w_state_nxt = r_state;
    w_lo_nxt    = r_lo;
    w_hi_nxt    = r_hi;
    w_carry_nxt = 1'b0;

    if (w_count) begin
      if (r_lo != 4'd9) begin
        w_lo_nxt = r_lo + 4'd1;
      end else begin
        w_lo_nxt = 4'd0;
        if (r_hi == c_hi_last) begin
          w_hi_nxt    = 3'd0;
          w_carry_nxt = 1'b1;
        end else begin
          w_hi_nxt = r_hi + 3'd1;
        end
      end
    end

    // Clear outranks a simultaneous press when paused.
    case (r_state)
      S_IDLE: if (w_press) w_state_nxt = S_RUN;
      S_RUN:  if (w_press) w_state_nxt = S_STOP;
      S_STOP: begin
        if (bus.i_sw2) begin
          w_state_nxt = S_IDLE;
          w_lo_nxt    = 4'd0;
          w_hi_nxt    = 3'd0;
        end else if (w_press) begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_lo_nxt    = 4'd0;
        w_hi_nxt    = 3'd0;
      end
    endcase
  end

  // SW1_D resets high so a switch held through reset does not count as a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sw1_d <= 1'b1;
      r_lo    <= 4'd0;
      r_hi    <= 3'd0;
      r_carry <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sw1_d <= bus.i_sw1;
      r_lo    <= w_lo_nxt;
      r_hi    <= w_hi_nxt;
      r_carry <= w_carry_nxt;
    end
  end

  assign bus.o_lo    = r_lo;
  assign bus.o_hi    = r_hi;
  assign bus.o_carry = r_carry;
  assign bus.o_run   = (r_state == S_RUN);
  assign bus.o_state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_sec60_upcounter.sv
// ============================================================================
// tb_sec60_upcounter : checks MOD_HI=6 and MOD_HI=3 counters side by side | rev 1.0
// ============================================================================
`default_nettype none

module tb_sec60_upcounter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw1 = 1'b1;
  logic sw2 = 1'b0;
  logic tick = 1'b0;

  always #5 clk = ~clk;

  sec60_upcounter_if b6 ();
  sec60_upcounter_if b3 ();

  assign b6.i_sw1 = sw1;  assign b6.i_sw2 = sw2;  assign b6.i_tick = tick;
  assign b3.i_sw1 = sw1;  assign b3.i_sw2 = sw2;  assign b3.i_tick = tick;

  sec60_upcounter #(.MOD_HI(6)) u6 (.clk(clk), .rst(rst), .bus(b6.slave));
  sec60_upcounter #(.MOD_HI(3)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));

  int d_lo[2], d_hi[2], d_car[2], d_run[2], d_st[2];
  always_comb begin
    d_lo[0] = int'(b6.o_lo);  d_hi[0] = int'(b6.o_hi);  d_car[0] = int'(b6.o_carry);
    d_run[0] = int'(b6.o_run); d_st[0] = int'(b6.o_state);
    d_lo[1] = int'(b3.o_lo);  d_hi[1] = int'(b3.o_hi);  d_car[1] = int'(b3.o_carry);
    d_run[1] = int'(b3.o_run); d_st[1] = int'(b3.o_state);
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: count held as one integer 0..10*MOD_HI-1; state 0 idle, 1 run, 2 stop.
  int mod_v[2] = '{6, 3};
  int mcnt[2], mst[2], mcar[2];
  bit mprev;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mprev = 1'b1;
      for (int i = 0; i < 2; i++) begin
        mcnt[i] = 0; mst[i] = 0; mcar[i] = 0;
      end
    end else begin
      bit press;
      press = sw1 && !mprev;
      mprev = sw1;
      for (int i = 0; i < 2; i++) begin
        mcar[i] = 0;
        if (mst[i] == 1 && tick) begin
          if (mcnt[i] + 1 == mod_v[i] * 10) begin
            mcnt[i] = 0; mcar[i] = 1;
          end else begin
            mcnt[i] = mcnt[i] + 1;
          end
        end
        if (mst[i] == 0) begin
          if (press) mst[i] = 1;
        end else if (mst[i] == 1) begin
          if (press) mst[i] = 2;
        end else begin
          if (sw2) begin
            mst[i] = 0; mcnt[i] = 0;
          end else if (press) begin
            mst[i] = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk(i == 0 ? "m6_lo"    : "m3_lo",    d_lo[i],  mcnt[i] % 10);
      chk(i == 0 ? "m6_hi"    : "m3_hi",    d_hi[i],  mcnt[i] / 10);
      chk(i == 0 ? "m6_carry" : "m3_carry", d_car[i], mcar[i]);
      chk(i == 0 ? "m6_run"   : "m3_run",   d_run[i], (mst[i] == 1) ? 1 : 0);
      chk(i == 0 ? "m6_state" : "m3_state", d_st[i],  mst[i]);
    end
  end

  task automatic cyc(input bit a, input bit b, input bit t);
    @(negedge clk);
    sw1 = a; sw2 = b; tick = t;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b1);
  endtask

  task automatic lit(input string nm, input int i, input int lo, input int hi, input int st, input int car);
    chk({nm, "_lo"},    d_lo[i],  lo);
    chk({nm, "_hi"},    d_hi[i],  hi);
    chk({nm, "_state"}, d_st[i],  st);
    chk({nm, "_carry"}, d_car[i], car);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    lit("rst_now6", 0, 0, 0, 0, 0);
    lit("rst_now3", 1, 0, 0, 0, 0);
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    lit("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    #2 rst = 1'b0;

    // SW1 held high through reset release: ticks must not count.
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 1'b1);
    lit("held_sw1", 0, 0, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("start_run", d_run[0], 1);

    // Full 60-tick lap on the MOD 6 counter.
    ticks(59);
    lit("at59", 0, 9, 5, 1, 0);
    ticks(1);
    lit("wrap60", 0, 0, 0, 1, 1);
    cyc(1'b0, 1'b0, 1'b0);
    lit("after_wrap", 0, 0, 0, 1, 0);

    // Pause at 23, ticks ignored, resume to 24.
    ticks(23);
    cyc(1'b1, 1'b0, 1'b0);
    lit("paused23", 0, 3, 2, 2, 0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    lit("hold23", 0, 3, 2, 2, 0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    lit("resume24", 0, 4, 2, 1, 0);

    // Pause at 37, then press and clear together: clear wins.
    ticks(13);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    lit("paused37", 0, 7, 3, 2, 0);
    cyc(1'b1, 1'b1, 1'b1);
    lit("clear_wins", 0, 0, 0, 0, 0);
    chk("clear_run", d_run[0], 0);

    // SW2 while running at 12 is ignored.
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    ticks(12);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    lit("sw2_run12", 0, 2, 1, 1, 0);

    // Same-cycle press+tick from RUN at 58 and from STOP at 59.
    ticks(46);
    lit("at58", 0, 8, 5, 1, 0);
    cyc(1'b1, 1'b0, 1'b1);
    lit("press_tick_run", 0, 9, 5, 2, 0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    lit("press_tick_stop", 0, 9, 5, 1, 0);

    // Async reset just before the wrapping edge cancels the carry.
    @(negedge clk);
    sw1 = 1'b0; tick = 1'b1;
    #2 rst = 1'b1;
    #1;
    lit("rst_at59", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    lit("no_carry59", 0, 0, 0, 0, 0);
    @(negedge clk);
    tick = 1'b0;
    #2 rst = 1'b0;

    // Three-tens counter: wraps after 29; then reset at 29 on both.
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    ticks(29);
    lit("m3_at29", 1, 9, 2, 1, 0);
    ticks(1);
    lit("m3_wrap", 1, 0, 0, 1, 1);
    lit("m6_at30", 0, 0, 3, 1, 0);
    ticks(29);
    lit("m3_29b", 1, 9, 2, 1, 0);
    lit("m6_59b", 0, 9, 5, 1, 0);
    @(negedge clk);
    tick = 1'b1;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    lit("m3_rst_nocarry", 1, 0, 0, 0, 0);
    lit("m6_rst_nocarry", 0, 0, 0, 0, 0);
    @(negedge clk);
    tick = 1'b0;
    #2 rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    chk("m3_carry_after", d_car[1], 0);

    async_reset();
    cyc(1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
